cmd_ingress_queue: RTL and testbench
====================================

# cmd_ingress_queue

Packet-aware command buffer between the host write port (AXI-Lite register bridge) and `command_processor`. It stores raw 32-bit command words in a circular buffer and releases a command downstream only after its header and all payload words are buffered. `command_processor` therefore never stalls mid-command waiting on the host. Overflowing or malformed packets are dropped whole, and sticky error flags are raised.

## Interface
Parameters:
- `DEPTH`, 16: buffer depth in words; power of two, ≥ 8.
- `ADDR_W`, `$clog2(DEPTH)`: derived index width.

Ports:
- `clk`, in, 1: single clock.
- `rst_n`, in, 1: active-low reset, asynchronous assert.
- `host_wr_en`, in, 1: host pushes `host_wr_data` this cycle. No backpressure.
- `host_wr_data`, in, 32: command word. Header format is `{opcode[31:24], rsvd[23:16], len[15:0]}`.
- `cmd_valid`, out, 1: a committed word is available.
- `cmd_data`, out, 32: word at the read pointer.
- `cmd_ready`, in, 1: `command_processor` accepts the word.
- `flush`, in, 1: synchronous discard of all contents.
- `err_clear`, in, 1: clears both sticky errors.
- `level`, out, ADDR_W+1: count of committed, unread words.
- `overflow_err`, out, 1: sticky. A packet was dropped for lack of space.
- `malformed_err`, out, 1: sticky. A header had `len + 1 > DEPTH`.

## Operation
- Storage is a flop array. It has three ADDR_W+1-bit wrapping pointers: `rd_ptr`, `cm_ptr` (commit), and `wr_ptr` (speculative).
- `used = wr_ptr - rd_ptr` and `level = cm_ptr - rd_ptr`. Both use modulo 2^(ADDR_W+1) arithmetic.
- A write has space when `used < DEPTH`. `used` comes from registered pointers, so a read in the same cycle does not free space until the next cycle.
- Writer FSM:
  - W_HDR:
    - On a push, latch `rem = len`.
    - If `len + 1 > DEPTH`: set `malformed_err`, go to W_DROP with `rem = len` (the header is not stored).
    - Otherwise, if there is no space: set `overflow_err`, go to W_DROP with `rem = len`.
    - Otherwise store the header. If `len == 0`, set `cm_ptr ← wr_ptr + 1` and stay in W_HDR. Else go to W_PAY.
  - W_PAY:
    - On a push with space: store the word and decrement `rem`. On the last word, set `cm_ptr ← wr_ptr + 1` and go to W_HDR.
    - On a push without space: roll `wr_ptr` back to `cm_ptr`, set `overflow_err`, `rem ← rem - 1`. Go to W_DROP, or to W_HDR if `rem` reaches 0.
  - W_DROP: each push decrements `rem` and stores nothing. Return to W_HDR once `rem` reaches 0. If `len` was 0, W_DROP is skipped.
- Reader:
  - `cmd_valid = (rd_ptr != cm_ptr)` and `cmd_data = mem[rd_ptr[ADDR_W-1:0]]`.
  - A transfer occurs on `cmd_valid && cmd_ready`, and `rd_ptr` increments.
  - Words come out in write order. Uncommitted words are never visible.
- `flush` has priority over host and reader activity in the same cycle:
  - all pointers are set to 0, FSM goes to W_HDR, `rem` is set to 0;
  - that cycle's `host_wr_en` is ignored;
  - error flags are retained.
- `err_clear` clears both flags. A new error event in the same cycle wins, so the flag stays 1.

## Timing
- Reset values:
  - pointers 0, FSM W_HDR, `rem` 0;
  - `cmd_valid` 0, `cmd_data` equal to mem[0] (don't-care; mem is not reset), `level` 0;
  - `overflow_err` 0, `malformed_err` 0.
- Reset mid-packet discards everything.
- Commit latency: `cmd_valid` rises the cycle after the final word of a packet is pushed (or the header, when `len == 0`). There is no combinational path from `host_wr_en` to `cmd_valid`.
- Throughput: one push and one pop per cycle, sustained and concurrent.
- `cmd_valid` and `cmd_data` hold stable while `cmd_ready` is low.
- Full buffer: `used == DEPTH`. Empty: `rd_ptr == cm_ptr`. Pointer wrap is correct across the 2^(ADDR_W+1) boundary.

## Structure
- `gfx_pkg` holds:
  - `cmd_word_t`;
  - header field constants: `OPC_MSB` = 31, `OPC_LSB` = 24, `LEN_MSB` = 15, `LEN_LSB` = 0;
  - opcodes: `OP_CLEAR` = 0x01, `OP_DRAW_TRI` = 0x02, `OP_SET_COLOR` = 0x10, `OP_SET_VIEWPORT` = 0x11;
  - the writer FSM enum.
- One sub-module, `cmd_queue_mem`: DEPTH×32 storage with synchronous write and asynchronous read. Pointer and FSM logic stay in the top module.

## Test plan
- SET_VIEWPORT push with `cmd_ready` = 1: push `0x11000004, 0, 0, 4, 3` back-to-back. `cmd_valid` stays 0 through the 5th push, rises the next cycle, then delivers the 5 words in order on consecutive cycles.
- CLEAR push: push `0x01000000`. `cmd_valid` = 1 exactly one cycle later and `level` = 1. After one transfer, `level` = 0 and `cmd_valid` = 0.
- Backpressure: with `cmd_ready` = 0, push 3 SET_COLOR packets (`0x10000001, 0xFF0000`, ×3). `level` = 6 and `cmd_data` holds `0x10000001`. Raise `cmd_ready`: 6 words leave in order and `level` returns to 0.
- Overflow (DEPTH = 16):
  - With `cmd_ready` = 0, push two DRAW_TRIANGLE packets (`0x02000006` + 6 words each), giving `level` = 14.
  - Push a third DRAW_TRIANGLE: `overflow_err` = 1, `level` stays 14, and all 7 words are swallowed.
  - A following `0x01000000` commits, giving `level` = 15.
- Malformed: push `0x02000014` (`len` = 20) plus 20 words. `malformed_err` = 1 and `level` = 0. A following SET_COLOR is delivered intact. `err_clear` returns the flag to 0.
- Flush and reset mid-packet:
  - After 3 words of a DRAW_TRIANGLE, assert `flush`: `level` = 0 and the next `0x01000000` commits normally.
  - Repeat with `rst_n` = 0 instead of `flush`: all outputs return to their reset values.

Source files
------------

// File: rtl/gfx_pkg.sv
// Shared types and constants for the graphics command path: header layout,
// opcodes and the ingress writer FSM encoding.
package gfx_pkg;

  typedef logic [31:0] cmd_word_t;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 24;
  localparam int LEN_MSB = 15;
  localparam int LEN_LSB = 0;

  localparam logic [7:0] OP_CLEAR        = 8'h01;
  localparam logic [7:0] OP_DRAW_TRI     = 8'h02;
  localparam logic [7:0] OP_SET_COLOR    = 8'h10;
  localparam logic [7:0] OP_SET_VIEWPORT = 8'h11;

  typedef enum logic [1:0] {
    W_HDR,
    W_PAY,
    W_DROP
  } wr_state_e;

  function automatic logic [15:0] hdr_len(input cmd_word_t w);
    return w[LEN_MSB:LEN_LSB];
  endfunction

  function automatic cmd_word_t make_hdr(input logic [7:0] op, input logic [15:0] len);
    cmd_word_t w;
    w = '0;
    w[OPC_MSB:OPC_LSB] = op;
    w[LEN_MSB:LEN_LSB] = len;
    return w;
  endfunction

endpackage

// File: rtl/cmd_queue_mem.sv
// Command word storage: synchronous write port, asynchronous read port.
module cmd_queue_mem
  import gfx_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  cmd_word_t         wdata,
  input  logic [ADDR_W-1:0] raddr,
  output cmd_word_t         rdata
);

  cmd_word_t mem [DEPTH];

  // NOTE: storage is deliberately not reset; the pointers alone define which
  // entries are valid, and a reset would turn the array into costly flops with
  // reset muxes for no functional gain.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cmd_ingress_queue.sv
// Packet-aware ingress buffer: words are written speculatively and only
// become visible to the reader once the whole command has arrived.
module cmd_ingress_queue
  import gfx_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            host_wr_en,
  input  cmd_word_t       host_wr_data,
  output logic            cmd_valid,
  output cmd_word_t       cmd_data,
  input  logic            cmd_ready,
  input  logic            flush,
  input  logic            err_clear,
  output logic [ADDR_W:0] level,
  output logic            overflow_err,
  output logic            malformed_err
);

  typedef logic [ADDR_W:0] ptr_t;
  localparam ptr_t        PTR_ONE  = ptr_t'(1);
  localparam ptr_t        FULL_CNT = ptr_t'(DEPTH);
  localparam logic [15:0] LEN_MAX  = 16'(DEPTH);

  wr_state_e   state_q, state_d;
  logic [15:0] rem_q, rem_d;
  ptr_t        rd_ptr_q, cm_ptr_q, cm_ptr_d, wr_ptr_q, wr_ptr_d;
  ptr_t        used;
  logic        push, space, mem_we, ovf_set, mal_set;
  logic [15:0] len;

  assign push  = host_wr_en && !flush;
  assign used  = wr_ptr_q - rd_ptr_q;
  assign space = used < FULL_CNT;
  assign len   = hdr_len(host_wr_data);

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    wr_ptr_d = wr_ptr_q;
    cm_ptr_d = cm_ptr_q;
    mem_we   = 1'b0;
    ovf_set  = 1'b0;
    mal_set  = 1'b0;
    if (push) begin
      unique case (state_q)
        W_HDR: begin
          rem_d = len;
          if (len >= LEN_MAX) begin
            mal_set = 1'b1;
            state_d = W_DROP;
          end else if (!space) begin
            ovf_set = 1'b1;
            if (len != 16'd0) state_d = W_DROP;
          end else begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (len == 16'd0) cm_ptr_d = wr_ptr_q + PTR_ONE;
            else              state_d  = W_PAY;
          end
        end
        W_PAY: begin
          rem_d = rem_q - 16'd1;
          if (space) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (rem_q == 16'd1) begin
              cm_ptr_d = wr_ptr_q + PTR_ONE;
              state_d  = W_HDR;
            end
          end else begin
            // Discard the partial packet; the rest of it is swallowed.
            wr_ptr_d = cm_ptr_q;
            ovf_set  = 1'b1;
            state_d  = (rem_q == 16'd1) ? W_HDR : W_DROP;
          end
        end
        W_DROP: begin
          rem_d = rem_q - 16'd1;
          if (rem_q == 16'd1) state_d = W_HDR;
        end
        default: state_d = W_HDR;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= W_HDR;
      rem_q    <= '0;
      rd_ptr_q <= '0;
      cm_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else if (flush) begin
      state_q  <= W_HDR;
      rem_q    <= '0;
      rd_ptr_q <= '0;
      cm_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      cm_ptr_q <= cm_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      if (cmd_valid && cmd_ready) rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // A fresh error event outranks a concurrent clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_err  <= 1'b0;
      malformed_err <= 1'b0;
    end else begin
      if (ovf_set)        overflow_err  <= 1'b1;
      else if (err_clear) overflow_err  <= 1'b0;
      if (mal_set)        malformed_err <= 1'b1;
      else if (err_clear) malformed_err <= 1'b0;
    end
  end

  assign cmd_valid = (rd_ptr_q != cm_ptr_q);
  assign level     = cm_ptr_q - rd_ptr_q;

  cmd_queue_mem #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .waddr(wr_ptr_q[ADDR_W-1:0]),
    .wdata(host_wr_data),
    .raddr(rd_ptr_q[ADDR_W-1:0]),
    .rdata(cmd_data)
  );

endmodule

// File: tb/tb_cmd_ingress_queue.sv
// Self-checking bench for cmd_ingress_queue: a scoreboard of words expected to
// be delivered, popped by a monitor on each transfer, plus directed checks.
module tb_cmd_ingress_queue;
  import gfx_pkg::*;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = $clog2(DEPTH);

  logic            clk = 1'b0;
  logic            rst_n;
  logic            host_wr_en;
  cmd_word_t       host_wr_data;
  logic            cmd_valid;
  cmd_word_t       cmd_data;
  logic            cmd_ready;
  logic            flush;
  logic            err_clear;
  logic [ADDR_W:0] level;
  logic            overflow_err;
  logic            malformed_err;

  int        total = 0;
  int        bad   = 0;
  cmd_word_t sb [$];

  cmd_ingress_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .host_wr_en   (host_wr_en),
    .host_wr_data (host_wr_data),
    .cmd_valid    (cmd_valid),
    .cmd_data     (cmd_data),
    .cmd_ready    (cmd_ready),
    .flush        (flush),
    .err_clear    (err_clear),
    .level        (level),
    .overflow_err (overflow_err),
    .malformed_err(malformed_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Monitor: every transfer must match the oldest expected word.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
      if (sb.size() == 0) check("unexpected_word", cmd_data, 32'hxxxx_xxxx);
      else                check("deliver", cmd_data, sb.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input cmd_word_t w);
    host_wr_en   = 1'b1;
    host_wr_data = w;
    step();
    host_wr_en   = 1'b0;
  endtask

  task automatic push_pkt(input cmd_word_t hdr, input int n, input cmd_word_t base, input bit keep);
    if (keep) sb.push_back(hdr);
    push(hdr);
    for (int i = 0; i < n; i++) begin
      if (keep) sb.push_back(cmd_word_t'(base + i));
      push(cmd_word_t'(base + i));
    end
  endtask

  cmd_word_t vp [5];

  initial begin
    rst_n = 1'b0; host_wr_en = 1'b0; host_wr_data = '0;
    cmd_ready = 1'b0; flush = 1'b0; err_clear = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(cmd_valid), 0);
    check("rst_level", 32'(level), 0);
    check("rst_ovf", 32'(overflow_err), 0);
    check("rst_mal", 32'(malformed_err), 0);
    step();
    rst_n = 1'b1;
    step();

    // SET_VIEWPORT with the reader always ready
    vp = '{32'h1100_0004, 32'h0, 32'h0, 32'h4, 32'h3};
    cmd_ready = 1'b1;
    foreach (vp[i]) sb.push_back(vp[i]);
    foreach (vp[i]) begin
      host_wr_en = 1'b1; host_wr_data = vp[i];
      @(negedge clk);
      check("vp_not_yet_valid", 32'(cmd_valid), 0);
      step();
    end
    host_wr_en = 1'b0;
    @(negedge clk);
    check("vp_valid_rise", 32'(cmd_valid), 1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("vp_all_out", 32'(sb.size()), 0);
    check("vp_valid_fall", 32'(cmd_valid), 0);
    step();

    // CLEAR: single-word commit latency and one transfer
    cmd_ready = 1'b0;
    sb.push_back(32'h0100_0000);
    host_wr_en = 1'b1; host_wr_data = 32'h0100_0000;
    @(negedge clk);
    check("clr_push_valid", 32'(cmd_valid), 0);
    step();
    host_wr_en = 1'b0;
    @(negedge clk);
    check("clr_valid", 32'(cmd_valid), 1);
    check("clr_level", 32'(level), 1);
    step();
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    @(negedge clk);
    check("clr_level_after", 32'(level), 0);
    check("clr_valid_after", 32'(cmd_valid), 0);
    step();

    // Backpressure: three SET_COLOR packets held, then drained
    for (int p = 0; p < 3; p++) push_pkt(32'h1000_0001, 1, 32'h00FF_0000, 1'b1);
    @(negedge clk);
    check("bp_level", 32'(level), 6);
    check("bp_data_hold", cmd_data, 32'h1000_0001);
    step();
    @(negedge clk);
    check("bp_data_stable", cmd_data, 32'h1000_0001);
    step();
    cmd_ready = 1'b1;
    repeat (6) step();
    @(negedge clk);
    check("bp_level_drained", 32'(level), 0);
    check("bp_sb_empty", 32'(sb.size()), 0);
    step();

    // Overflow: two DRAW_TRI fit, the third is dropped whole
    cmd_ready = 1'b0;
    push_pkt(make_hdr(OP_DRAW_TRI, 16'd6), 6, 32'hA000_0010, 1'b1);
    push_pkt(make_hdr(OP_DRAW_TRI, 16'd6), 6, 32'hA000_0020, 1'b1);
    @(negedge clk);
    check("ovf_level14", 32'(level), 14);
    check("ovf_flag_pre", 32'(overflow_err), 0);
    step();
    push_pkt(make_hdr(OP_DRAW_TRI, 16'd6), 6, 32'hBAD0_0000, 1'b0);
    @(negedge clk);
    check("ovf_flag", 32'(overflow_err), 1);
    check("ovf_level_kept", 32'(level), 14);
    step();
    push_pkt(32'h0100_0000, 0, 32'h0, 1'b1);
    @(negedge clk);
    check("ovf_level15", 32'(level), 15);
    step();
    cmd_ready = 1'b1;
    repeat (15) step();
    @(negedge clk);
    check("ovf_drained", 32'(level), 0);
    check("ovf_sb_empty", 32'(sb.size()), 0);
    step();
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    @(negedge clk);
    check("ovf_cleared", 32'(overflow_err), 0);
    step();

    // Malformed: len=20 dropped, following SET_COLOR intact
    push_pkt(32'h0200_0014, 20, 32'hDEAD_0000, 1'b0);
    @(negedge clk);
    check("mal_flag", 32'(malformed_err), 1);
    check("mal_level", 32'(level), 0);
    check("mal_valid", 32'(cmd_valid), 0);
    step();
    push_pkt(32'h1000_0001, 1, 32'h00FF_0000, 1'b1);
    repeat (3) step();
    @(negedge clk);
    check("mal_setcolor_out", 32'(sb.size()), 0);
    step();
    // Clear in the same cycle as a new malformed header: the error wins.
    err_clear = 1'b1;
    push(32'h0200_0014);
    err_clear = 1'b0;
    @(negedge clk);
    check("mal_err_wins", 32'(malformed_err), 1);
    step();
    for (int i = 0; i < 20; i++) push(cmd_word_t'(32'hDEAD_1000 + i));
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    @(negedge clk);
    check("mal_cleared", 32'(malformed_err), 0);
    step();

    // Flush mid-packet; the push in the flush cycle is ignored
    cmd_ready = 1'b0;
    push(make_hdr(OP_DRAW_TRI, 16'd6));
    push(32'hC000_0001);
    push(32'hC000_0002);
    flush = 1'b1; host_wr_en = 1'b1; host_wr_data = 32'h0100_0000;
    step();
    flush = 1'b0; host_wr_en = 1'b0;
    @(negedge clk);
    check("flush_level", 32'(level), 0);
    check("flush_valid", 32'(cmd_valid), 0);
    step();
    push_pkt(32'h0100_0000, 0, 32'h0, 1'b1);
    @(negedge clk);
    check("flush_commit", 32'(level), 1);
    step();
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    @(negedge clk);
    check("flush_drained", 32'(sb.size()), 0);
    step();

    // Reset mid-packet with errors set and a committed word pending
    push_pkt(32'h0200_0010, 16, 32'hEEEE_0000, 1'b0);
    push(32'h0100_0000);
    push(make_hdr(OP_DRAW_TRI, 16'd6));
    push(32'hC000_0011);
    push(32'hC000_0012);
    @(negedge clk);
    check("pre_rst_mal", 32'(malformed_err), 1);
    check("pre_rst_level", 32'(level), 1);
    step();
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", 32'(cmd_valid), 0);
    check("mid_rst_level", 32'(level), 0);
    check("mid_rst_ovf", 32'(overflow_err), 0);
    check("mid_rst_mal", 32'(malformed_err), 0);
    step();
    rst_n = 1'b1;
    step();
    push_pkt(32'h0100_0000, 0, 32'h0, 1'b1);
    @(negedge clk);
    check("post_rst_commit", 32'(level), 1);
    step();
    cmd_ready = 1'b1;
    step();
    @(negedge clk);
    check("post_rst_drained", 32'(sb.size()), 0);
    check("post_rst_level", 32'(level), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
